// File: rtl/sram_arb_pkg.sv
// Shared types and defaults for the two-port asynchronous SRAM arbiter.
package sram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  localparam int DEF_ACCESS_CYCLES = 2;
  localparam int DEF_ADDR_W        = 18;
  localparam int DEF_DATA_W        = 16;

endpackage

// File: rtl/sram_arbiter_rr_arb2.sv
// Two-request round-robin picker; the last-grant history is held by the parent.
module rr_arb2
  import sram_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant,
  output logic       valid
);

  // On a tie the port that was not served last wins.
  always_comb begin
    grant = PORT_A;
    valid = 1'b0;
    case (req)
      2'b01: begin
        grant = PORT_A;
        valid = 1'b1;
      end
      2'b10: begin
        grant = PORT_B;
        valid = 1'b1;
      end
      2'b11: begin
        grant = ~last_grant;
        valid = 1'b1;
      end
      default: begin
        grant = PORT_A;
        valid = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/sram_arbiter.sv
// Round-robin sharing of one asynchronous SRAM between two fixed-length requesters.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ACCESS_CYCLES = DEF_ACCESS_CYCLES,
  parameter int ADDR_W        = DEF_ADDR_W,
  parameter int DATA_W        = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  input  logic [1:0]        a_be,
  output logic              a_ack,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  input  logic [1:0]        b_be,
  output logic              b_ack,
  output logic [DATA_W-1:0] b_rdata,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_dq_out,
  output logic              sram_dq_oe,
  input  logic [DATA_W-1:0] sram_dq_in,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic              sram_ub_n,
  output logic              sram_lb_n
);

  localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);

  state_t            state_r, state_next_s;
  logic [3:0]        cnt_r, cnt_next_s;
  logic              last_grant_r, last_grant_next_s;
  logic              port_r, port_next_s;
  logic              we_r, we_next_s;
  logic [ADDR_W-1:0] addr_r, addr_next_s;
  logic [DATA_W-1:0] wdata_r, wdata_next_s;
  logic [1:0]        be_r, be_next_s;
  logic              grant_s, grant_valid_s;

  logic              ce_n_next_s, oe_n_next_s, we_n_next_s, ub_n_next_s, lb_n_next_s;
  logic              dq_oe_next_s, a_ack_next_s, b_ack_next_s;
  logic [DATA_W-1:0] a_rdata_next_s, b_rdata_next_s;

  rr_arb2 u_rr_arb2 (
    .req        ({b_req, a_req}),
    .last_grant (last_grant_r),
    .grant      (grant_s),
    .valid      (grant_valid_s)
  );

  // Address and write data come straight from the access registers, so they
  // stay put for the whole access including the hold cycle after WE_N rises.
  assign sram_addr   = addr_r;
  assign sram_dq_out = wdata_r;

  // Next-state, access-register and next-output logic.
  always_comb begin
    state_next_s      = state_r;
    cnt_next_s        = cnt_r;
    last_grant_next_s = last_grant_r;
    port_next_s       = port_r;
    we_next_s         = we_r;
    addr_next_s       = addr_r;
    wdata_next_s      = wdata_r;
    be_next_s         = be_r;
    a_ack_next_s      = 1'b0;
    b_ack_next_s      = 1'b0;
    a_rdata_next_s    = a_rdata;
    b_rdata_next_s    = b_rdata;
    ce_n_next_s       = 1'b1;
    oe_n_next_s       = 1'b1;
    we_n_next_s       = 1'b1;
    ub_n_next_s       = 1'b1;
    lb_n_next_s       = 1'b1;
    dq_oe_next_s      = 1'b0;

    case (state_r)
      IDLE: begin
        if (grant_valid_s) begin
          state_next_s = ACCESS;
          cnt_next_s   = CNT_LOAD;
          port_next_s  = grant_s;
          if (grant_s == PORT_B) begin
            we_next_s    = b_we;
            addr_next_s  = b_addr;
            wdata_next_s = b_wdata;
            be_next_s    = b_be;
          end else begin
            we_next_s    = a_we;
            addr_next_s  = a_addr;
            wdata_next_s = a_wdata;
            be_next_s    = a_be;
          end
        end else begin
          state_next_s = IDLE;
        end
      end
      ACCESS: begin
        if (cnt_r == 4'd0) begin
          state_next_s = DONE;
          a_ack_next_s = (port_r == PORT_A);
          b_ack_next_s = (port_r == PORT_B);
          if (!we_r && (port_r == PORT_B)) begin
            b_rdata_next_s = sram_dq_in;
          end else if (!we_r) begin
            a_rdata_next_s = sram_dq_in;
          end else begin
            a_rdata_next_s = a_rdata;
          end
        end else begin
          cnt_next_s = cnt_r - 4'd1;
        end
      end
      DONE: begin
        state_next_s      = IDLE;
        last_grant_next_s = port_r;
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase

    // Strobes are registered, so derive them from where the FSM is heading.
    if (state_next_s == ACCESS) begin
      ce_n_next_s = 1'b0;
      if (we_next_s) begin
        oe_n_next_s  = 1'b1;
        dq_oe_next_s = 1'b1;
        we_n_next_s  = (cnt_next_s == 4'd0);
        ub_n_next_s  = ~be_next_s[1];
        lb_n_next_s  = ~be_next_s[0];
      end else begin
        oe_n_next_s = 1'b0;
        ub_n_next_s = 1'b0;
        lb_n_next_s = 1'b0;
      end
    end else begin
      ce_n_next_s = 1'b1;
    end
  end

  // State, access registers and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= IDLE;
      cnt_r        <= 4'd0;
      last_grant_r <= PORT_B;
      port_r       <= PORT_A;
      we_r         <= 1'b0;
      addr_r       <= {ADDR_W{1'b0}};
      wdata_r      <= {DATA_W{1'b0}};
      be_r         <= 2'b00;
      a_ack        <= 1'b0;
      b_ack        <= 1'b0;
      a_rdata      <= {DATA_W{1'b0}};
      b_rdata      <= {DATA_W{1'b0}};
      sram_ce_n    <= 1'b1;
      sram_oe_n    <= 1'b1;
      sram_we_n    <= 1'b1;
      sram_ub_n    <= 1'b1;
      sram_lb_n    <= 1'b1;
      sram_dq_oe   <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      cnt_r        <= cnt_next_s;
      last_grant_r <= last_grant_next_s;
      port_r       <= port_next_s;
      we_r         <= we_next_s;
      addr_r       <= addr_next_s;
      wdata_r      <= wdata_next_s;
      be_r         <= be_next_s;
      a_ack        <= a_ack_next_s;
      b_ack        <= b_ack_next_s;
      a_rdata      <= a_rdata_next_s;
      b_rdata      <= b_rdata_next_s;
      sram_ce_n    <= ce_n_next_s;
      sram_oe_n    <= oe_n_next_s;
      sram_we_n    <= we_n_next_s;
      sram_ub_n    <= ub_n_next_s;
      sram_lb_n    <= lb_n_next_s;
      sram_dq_oe   <= dq_oe_next_s;
    end
  end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares the board's single 256K x 16 asynchronous SRAM between two internal requesters (port A, port B) using round-robin arbitration.
- Generates SRAM_ADDR, the control strobes and a split data bus. The top level owns the SRAM_DQ tristate: SRAM_DQ = sram_dq_oe ? sram_dq_out : 16'hzzzz.
- Runs on the 50 MHz system clock; each access is a fixed-length, non-pipelined transaction.

Parameters:
- ACCESS_CYCLES, 2, clocks the strobes are active per access; legal range 2..15 (2 = 40 ns at 50 MHz).
- ADDR_W, 18, SRAM word-address width.
- DATA_W, 16, SRAM data width.

Ports:
- clk  in  1  system clock (CLOCK_50 at top)
- reset_n  in  1  asynchronous active-low reset (KEY[0]-derived at top)
- a_req  in  1  port A request; held until a_ack
- a_we  in  1  1 = write, 0 = read
- a_addr  in  ADDR_W  word address
- a_wdata  in  DATA_W  write data
- a_be  in  2  byte enables; [1] = upper byte, [0] = lower byte
- a_ack  out  1  one-cycle completion pulse
- a_rdata  out  DATA_W  read data; valid when a_ack && !a_we
- b_req, b_we, b_addr, b_wdata, b_be, b_ack, b_rdata: same as port A
- sram_addr  out  ADDR_W  to SRAM_ADDR
- sram_dq_out  out  DATA_W  write data to pad
- sram_dq_oe  out  1  drive enable for SRAM_DQ
- sram_dq_in  in  DATA_W  SRAM_DQ read back
- sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n  out  1 each  active-low SRAM strobes

Behaviour:
- Clocking/reset: one clock; reset is asynchronous and active-low.
- Reset values:
  - state = IDLE, last_grant = B (so A wins the first tie).
  - All *_n strobes = 1, sram_dq_oe = 0, sram_addr = 0, sram_dq_out = 0.
  - a_ack = b_ack = 0, a_rdata = b_rdata = 0.
- FSM IDLE -> ACCESS -> DONE -> IDLE. All outputs are registered.
- IDLE:
  - Neither req: stay.
  - One req: grant it.
  - Both reqs: grant the port not equal to last_grant.
  - On grant, latch port id, we, addr, wdata and be into the access registers; load cnt = ACCESS_CYCLES-1; go to ACCESS.
- ACCESS (exactly ACCESS_CYCLES clocks):
  - ce_n = 0. ub_n = ~be[1] and lb_n = ~be[0] on writes; both 0 on reads.
  - Read: oe_n = 0, dq_oe = 0. On the last cycle (cnt == 0), register sram_dq_in into the granted port's rdata.
  - Write: oe_n = 1, dq_oe = 1 for the whole state. we_n = 0 while cnt != 0 and 1 on the last cycle, giving one clock of address/data hold after the WE_N rising edge.
  - cnt decrements each clock; at cnt == 0 go to DONE.
- DONE (1 clock):
  - All strobes = 1, dq_oe = 0.
  - Pulse the granted port's ack; last_grant <= granted port; go to IDLE.
- Latency: req first high in IDLE at cycle N, with no contention, gives ack in cycle N + ACCESS_CYCLES + 1 (cycle N+3 at default). Minimum request-to-request spacing for one port is ACCESS_CYCLES + 2.
- Client rules:
  - Inputs must stay stable while req is high until ack.
  - The requester drops req in the cycle after ack, or keeps it high to issue the next transaction.
  - A req withdrawn before grant is ignored.
- The arbiter never overlaps accesses, never asserts oe_n = 0 and dq_oe = 1 together, and never asserts we_n = 0 and oe_n = 0 together.
- Fairness: with both ports requesting continuously, grants strictly alternate A, B, A, B.
- be == 2'b00 on a write: full transaction still runs with ub_n = lb_n = 1; ack still pulses and memory is unchanged.
- Address wrap: none. Addresses pass through unmodified.
- Reset mid-access: strobes deassert and dq_oe drops asynchronously; no ack is issued; the transaction is lost.

Decomposition:
- Package sram_arb_pkg:
  - state typedef (IDLE, ACCESS, DONE).
  - port-id constants PORT_A = 0, PORT_B = 1.
  - Default ACCESS_CYCLES, ADDR_W and DATA_W.
- Sub-module rr_arb2: two-request round-robin picker that takes req[1:0] and last_grant and returns grant id plus a valid flag. Purely combinational; last_grant state stays in the parent.

Test Plan:
- Reset: hold reset_n = 0 -> all strobes 1, dq_oe 0, acks 0; drop reset_n mid-ACCESS -> strobes go to 1 without waiting for a clock edge, and no ack follows.
- Single write: A writes addr 18'h00123, data 16'hBEEF, be 2'b11, ACCESS_CYCLES = 2 -> we_n low exactly 1 clock, dq_oe high 2 clocks, a_ack at cycle N+3; SRAM model word 0x123 = 0xBEEF.
- Single read: B reads 18'h00123 with the model returning 16'hBEEF -> oe_n low 2 clocks, b_ack at N+3 with b_rdata = 16'hBEEF, a_ack stays 0.
- Contention: A and B raise req in the same cycle from reset -> A served first, then B; over 8 back-to-back requests per port the grant order alternates exactly.
- Byte write: write 16'h12FF with be 2'b01 over existing 16'hBEEF -> lb_n low and ub_n high during ACCESS; read back gives 16'hBEFF.
- Parameter sweep: ACCESS_CYCLES = 5 -> ack at N+6; we_n low 4 clocks; checker reports zero dq_oe/oe_n and we_n/oe_n overlaps.
